// File: rtl/seq_step_ctrl.sv
// Step-sequencer controller: debounced pushbuttons, play/pause/stop FSM with tempo counter,
// and the step / tone-ROM address / frequency outputs feeding the display and tone generator.
module seq_step_ctrl #(
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int DB_TICKS       = 500_000,
    parameter int SEQ_LEN        = 16
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic       KEY2,
    input  logic       KEY3,
    input  logic [1:0] bank,
    input  logic [6:0] rom_data,
    output logic [6:0] rom_addr,
    output logic [6:0] seq_num,
    output logic [6:0] freq_num,
    output logic       note_on,
    output logic       step_tick,
    output logic [1:0] state
);
    localparam int TW  = $clog2(TICKS_PER_STEP);
    localparam int DBW = $clog2(DB_TICKS + 1);

    localparam logic [TW-1:0]  TEMPO_LAST = TW'(TICKS_PER_STEP - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_TICKS - 1);
    localparam logic [4:0]     STEP_LAST  = 5'(SEQ_LEN - 1);

    // Key slots in the debounce vectors.
    localparam int K_PLAY = 0;
    localparam int K_STEP = 1;
    localparam int K_STOP = 2;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = CLOCK_50;
    assign rst_n = KEY0;

    logic [2:0]     key_raw;
    logic [2:0]     key_s1;
    logic [2:0]     key_s2;
    logic [2:0]     deb;
    logic [2:0]     press;
    logic [DBW-1:0] db_cnt [3];
    logic [1:0]     bank_s1;
    logic [1:0]     bank_s2;

    state_t         state_q, state_d;
    logic [4:0]     step_q, step_d, step_inc;
    logic [TW-1:0]  tempo_q, tempo_d;
    logic           tick_q, tick_d;
    logic [6:0]     freq_q;

    assign key_raw = {KEY3, KEY2, KEY1};

    // NOTE: every flop here, the small counter array included, is cleared by the async reset;
    // the block has no RAM, so nothing is left to power-up state.
    // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= '1;
            key_s2 <= '1;
            deb    <= '1;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
            for (int i = 0; i < 3; i++) begin
                if (key_s2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= key_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // A press fires on the edge where the debounced level falls, so the FSM acts on that same edge.
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++) begin
            press[i] = deb[i] & ~key_s2[i] & (db_cnt[i] == DB_LAST);
        end
    end

    assign step_inc = (step_q == STEP_LAST) ? 5'd0 : step_q + 5'd1;

    // NOTE: all outputs of this block get a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tempo_d = tempo_q;
        tick_d  = 1'b0;
        if (press[K_STOP]) begin
            state_d = ST_STOP;
            step_d  = '0;
            tempo_d = '0;
        end else if (press[K_PLAY]) begin
            case (state_q)
                ST_STOP: begin
                    state_d = ST_PLAY;
                    step_d  = '0;
                    tempo_d = '0;
                end
                ST_PLAY: state_d = ST_PAUSE;
                default: state_d = ST_PLAY;
            endcase
        end else if (state_q == ST_PLAY) begin
            // Single-step is ignored while playing; the tempo keeps running.
            if (tempo_q == TEMPO_LAST) begin
                tempo_d = '0;
                step_d  = step_inc;
                tick_d  = 1'b1;
            end else begin
                tempo_d = tempo_q + TW'(1);
            end
        end else if (press[K_STEP]) begin
            step_d = step_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            step_q  <= '0;
            tempo_q <= '0;
            tick_q  <= 1'b0;
            bank_s1 <= '0;
            bank_s2 <= '0;
            freq_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tempo_q <= tempo_d;
            tick_q  <= tick_d;
            bank_s1 <= bank;
            bank_s2 <= bank_s1;
            freq_q  <= rom_data;
        end
    end

    // The ROM address is unregistered so the external ROM's own latency is the only delay.
    assign rom_addr  = {bank_s2, step_q};
    assign seq_num   = {2'b00, step_q};
    assign freq_num  = freq_q;
    assign note_on   = (state_q == ST_PLAY);
    assign step_tick = tick_q;
    assign state     = state_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Bench for seq_step_ctrl: a vector table, hand-written corner sequences and a randomized
// run against a cycle-level reference model, all with a 1-cycle ROM returning addr + 10.
module tb_seq_step_ctrl;
    localparam int TPS = 4;
    localparam int DBT = 3;
    localparam int SL  = 5;
    localparam int NR  = 3000;
    localparam int OFF = 4;

    logic       CLOCK_50 = 1'b0;
    logic       KEY0 = 1'b0;
    logic       KEY1 = 1'b1;
    logic       KEY2 = 1'b1;
    logic       KEY3 = 1'b1;
    logic [1:0] bank = 2'd0;
    logic [6:0] rom_data = 7'd0;
    logic [6:0] rom_addr;
    logic [6:0] seq_num;
    logic [6:0] freq_num;
    logic       note_on;
    logic       step_tick;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    seq_step_ctrl #(.TICKS_PER_STEP(TPS), .DB_TICKS(DBT), .SEQ_LEN(SL)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY0     (KEY0),
        .KEY1     (KEY1),
        .KEY2     (KEY2),
        .KEY3     (KEY3),
        .bank     (bank),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .seq_num  (seq_num),
        .freq_num (freq_num),
        .note_on  (note_on),
        .step_tick(step_tick),
        .state    (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Tone ROM stand-in: synchronous, one cycle of read latency.
    always @(posedge CLOCK_50) rom_data <= rom_addr + 7'd10;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // keys = {KEY3, KEY2, KEY1}, raw active-low; expectations are sampled after ncyc edges.
    typedef struct {
        bit [2:0] keys;
        bit [1:0] bk;
        int       ncyc;
        int       e_state;
        int       e_seq;
        int       e_note;
        int       e_tick;
        int       e_rom;
        int       e_freq;
    } vec_t;

    vec_t vecs [15];

    int ev_at     [NR + 16];
    int bank_drv  [NR + 16];
    int addr_hist [NR + 16];

    initial begin
        int nt;
        int m_st, m_step, m_tempo, m_tick;
        int rem, gap, r, pk, len, ev, addr;
        logic [31:0] exp_v, act_v;

        vecs[0]  = '{3'b101, 2'd0, 6, 0, 1, 0, 0,  1, 10};
        vecs[1]  = '{3'b111, 2'd0, 6, 0, 1, 0, 0,  1, 11};
        vecs[2]  = '{3'b101, 2'd0, 2, 0, 1, 0, 0,  1, 11};
        vecs[3]  = '{3'b111, 2'd0, 1, 0, 1, 0, 0,  1, 11};
        vecs[4]  = '{3'b101, 2'd0, 2, 0, 1, 0, 0,  1, 11};
        vecs[5]  = '{3'b111, 2'd0, 6, 0, 1, 0, 0,  1, 11};
        vecs[6]  = '{3'b110, 2'd0, 5, 1, 0, 1, 0,  0, 11};
        vecs[7]  = '{3'b111, 2'd0, 4, 1, 1, 1, 1,  1, 10};
        vecs[8]  = '{3'b111, 2'd0, 2, 1, 1, 1, 0,  1, 11};
        vecs[9]  = '{3'b011, 2'd0, 5, 0, 0, 0, 0,  0, 12};
        vecs[10] = '{3'b111, 2'd0, 6, 0, 0, 0, 0,  0, 10};
        vecs[11] = '{3'b111, 2'd1, 3, 0, 0, 0, 0, 32, 10};
        vecs[12] = '{3'b111, 2'd1, 1, 0, 0, 0, 0, 32, 42};
        vecs[13] = '{3'b101, 2'd1, 6, 0, 1, 0, 0, 33, 42};
        vecs[14] = '{3'b111, 2'd1, 2, 0, 1, 0, 0, 33, 43};

        // Reset state
        repeat (3) tick();
        check("rst state", 32'(state), 0);
        check("rst seq", 32'(seq_num), 0);
        check("rst rom_addr", 32'(rom_addr), 0);
        check("rst freq", 32'(freq_num), 0);
        check("rst note_on", 32'(note_on), 0);
        check("rst step_tick", 32'(step_tick), 0);
        KEY0 = 1'b1;
        repeat (2) tick();

        // Vector table: bounce rejection, play entry, tempo, stop, bank path
        for (int i = 0; i < 15; i++) begin
            {KEY3, KEY2, KEY1} = vecs[i].keys;
            bank = vecs[i].bk;
            repeat (vecs[i].ncyc) tick();
            check($sformatf("row%0d state", i), 32'(state), 32'(vecs[i].e_state));
            check($sformatf("row%0d seq", i), 32'(seq_num), 32'(vecs[i].e_seq));
            check($sformatf("row%0d note_on", i), 32'(note_on), 32'(vecs[i].e_note));
            check($sformatf("row%0d step_tick", i), 32'(step_tick), 32'(vecs[i].e_tick));
            check($sformatf("row%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].e_rom));
            check($sformatf("row%0d freq", i), 32'(freq_num), 32'(vecs[i].e_freq));
        end

        // Asynchronous reset in PLAY at step 3
        {KEY3, KEY2, KEY1} = 3'b111;
        repeat (6) tick();
        KEY1 = 1'b0;
        repeat (5) tick();
        check("play entry state", 32'(state), 1);
        KEY1 = 1'b1;
        repeat (12) tick();
        check("pre-reset seq", 32'(seq_num), 3);
        check("pre-reset step_tick", 32'(step_tick), 1);
        #3;
        KEY0 = 1'b0;
        bank = 2'd0;
        #1;
        check("async rst state", 32'(state), 0);
        check("async rst seq", 32'(seq_num), 0);
        check("async rst rom_addr", 32'(rom_addr), 0);
        check("async rst freq", 32'(freq_num), 0);
        check("async rst note_on", 32'(note_on), 0);
        check("async rst step_tick", 32'(step_tick), 0);
        tick();
        tick();
        KEY0 = 1'b1;
        repeat (2) tick();

        // Pause at tempo 2, hold, resume: next tick 2 cycles after resume
        KEY1 = 1'b0;
        repeat (5) tick();
        KEY1 = 1'b1;
        repeat (6) tick();
        KEY1 = 1'b0;
        repeat (5) tick();
        check("pause state", 32'(state), 2);
        check("pause note_on", 32'(note_on), 0);
        check("pause seq", 32'(seq_num), 2);
        KEY1 = 1'b1;
        nt = 0;
        repeat (20) begin
            tick();
            nt += int'(step_tick);
        end
        check("pause tick count", 32'(nt), 0);
        check("pause seq held", 32'(seq_num), 2);
        KEY1 = 1'b0;
        repeat (5) tick();
        check("resume state", 32'(state), 1);
        check("resume note_on", 32'(note_on), 1);
        KEY1 = 1'b1;
        tick();
        check("resume+1 step_tick", 32'(step_tick), 0);
        tick();
        check("resume+2 step_tick", 32'(step_tick), 1);
        check("resume+2 seq", 32'(seq_num), 3);

        // Simultaneous KEY1/KEY2/KEY3 in PLAY at step 3: stop wins
        repeat (17) tick();
        {KEY3, KEY2, KEY1} = 3'b000;
        repeat (4) tick();
        check("prio pre seq", 32'(seq_num), 3);
        check("prio pre state", 32'(state), 1);
        tick();
        check("prio state", 32'(state), 0);
        check("prio seq", 32'(seq_num), 0);
        check("prio step_tick", 32'(step_tick), 0);
        check("prio note_on", 32'(note_on), 0);
        nt = 0;
        repeat (4) begin
            tick();
            nt += int'(step_tick);
        end
        check("prio after tick count", 32'(nt), 0);
        check("prio after seq", 32'(seq_num), 0);
        {KEY3, KEY2, KEY1} = 3'b111;
        repeat (6) tick();

        // Bank switch at step 2
        repeat (2) begin
            KEY2 = 1'b0;
            repeat (5) tick();
            KEY2 = 1'b1;
            repeat (6) tick();
        end
        check("bank pre rom_addr", 32'(rom_addr), 2);
        check("bank pre freq", 32'(freq_num), 12);
        bank = 2'd2;
        tick();
        check("bank +1 rom_addr", 32'(rom_addr), 2);
        tick();
        check("bank +2 rom_addr", 32'(rom_addr), 66);
        tick();
        check("bank +3 freq", 32'(freq_num), 12);
        tick();
        check("bank +4 freq", 32'(freq_num), 76);

        // Randomized run against the reference model
        KEY0 = 1'b0;
        bank = 2'd0;
        {KEY3, KEY2, KEY1} = 3'b111;
        repeat (2) tick();
        KEY0 = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < NR + 16; i++) begin
            ev_at[i]     = 0;
            bank_drv[i]  = 0;
            addr_hist[i] = 0;
        end
        m_st = 0;
        m_step = 0;
        m_tempo = 0;
        rem = 0;
        gap = 3;
        for (int n = 1; n <= NR; n++) begin
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    {KEY3, KEY2, KEY1} = 3'b111;
                    gap = $urandom_range(6, 12);
                end
            end else if (gap > 0) begin
                gap--;
            end else begin
                r   = $urandom_range(0, 99);
                pk  = (r < 45) ? 0 : (r < 85) ? 1 : 2;
                len = $urandom_range(1, 10);
                case (pk)
                    0:       KEY1 = 1'b0;
                    1:       KEY2 = 1'b0;
                    default: KEY3 = 1'b0;
                endcase
                rem = len;
                // A low pulse of at least DBT samples is one press, acting DBT+1 edges after its first sample.
                if (len >= DBT) ev_at[n + DBT + 1 + OFF] = pk + 1;
                if ($urandom_range(0, 3) == 0) bank = 2'($urandom_range(0, 3));
            end
            bank_drv[n + OFF] = int'(bank);
            tick();

            ev = ev_at[n + OFF];
            m_tick = 0;
            if (ev == 3) begin
                m_st = 0;
                m_step = 0;
                m_tempo = 0;
            end else if (ev == 1) begin
                if (m_st == 0) begin
                    m_st = 1;
                    m_step = 0;
                    m_tempo = 0;
                end else begin
                    m_st = (m_st == 1) ? 2 : 1;
                end
            end else if (m_st == 1) begin
                m_tempo++;
                if (m_tempo == TPS) begin
                    m_tempo = 0;
                    m_step = (m_step + 1) % SL;
                    m_tick = 1;
                end
            end else if (ev == 2) begin
                m_step = (m_step + 1) % SL;
            end
            addr = bank_drv[n - 1 + OFF] * 32 + m_step;
            addr_hist[n + OFF] = addr;
            exp_v = {7'd0, 2'(m_st), 1'(m_st == 1), 1'(m_tick), 7'(m_step), 7'(addr),
                     7'(addr_hist[n - 2 + OFF] + 10)};
            act_v = {7'd0, state, note_on, step_tick, seq_num, rom_addr, freq_num};
            check($sformatf("rand edge %0d {st,note,tick,seq,addr,freq}", n), act_v, exp_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_step_ctrl.md
# seq_step_ctrl

Step-sequencer controller that sits directly upstream of the seven-segment display stage. It debounces the board pushbuttons, runs a play/pause/stop state machine with a tempo counter, and produces the current step number (`seq_num`). It also drives the tone ROM address (`rom_addr`) and the registered ROM output (`freq_num`), and these three values feed the display stage and the tone generator.

## Interface
- `TICKS_PER_STEP`, default 12_500_000: clock cycles per sequencer step (0.25 s at 50 MHz); minimum 2.
- `DB_TICKS`, default 500_000: cycles a key must be stable before a change is accepted (10 ms); minimum 1.
- `SEQ_LEN`, default 16: steps per sequence, 1..32.
- `CLOCK_50` in 1: the single clock. All logic is on the rising edge.
- `KEY0` in 1: reset, asynchronous, active-low. Clears every register.
- `KEY1` in 1: play/pause pushbutton, raw, active-low.
- `KEY2` in 1: single-step pushbutton, raw, active-low.
- `KEY3` in 1: stop/restart pushbutton, raw, active-low.
- `bank` in 2: ROM bank select from switches, raw asynchronous.
- `rom_data` in 7: frequency index returned by the external synchronous ROM, 1-cycle read latency.
- `rom_addr` out 7: `{bank_sync, step[4:0]}`, combinational from registers.
- `seq_num` out 7: current step, `{2'b00, step}`, range 0..SEQ_LEN-1.
- `freq_num` out 7: `rom_data` registered every cycle.
- `note_on` out 1: high while in PLAY.
- `step_tick` out 1: one-cycle pulse when the tempo counter advances the step.
- `state` out 2: STOP=0, PLAY=1, PAUSE=2.

## Operation
- **Synchronisers.** `KEY1`–`KEY3` and `bank` each pass through a 2-flop synchroniser. Reset value is 1 for the keys and 0 for `bank`.
- **Debounce, per key.**
  - Each key has a counter and a debounced value `deb`, which resets to 1.
  - On each edge where the synced value ≠ `deb`: the counter increments. When the synced value has differed on DB_TICKS consecutive edges, `deb` takes the synced value and the counter clears.
  - Any edge where the synced value = `deb` clears the counter.
  - A press event is the edge on which `deb` goes 1→0. Release events cause no action. A held key produces exactly one event.
- **Event priority** on the same edge: KEY3 > KEY1 > KEY2. Only the highest-priority event acts.
- **FSM transitions:**
  - STOP + KEY1: go to PLAY; step=0; tempo=0.
  - PLAY + KEY1: go to PAUSE; tempo holds its value.
  - PAUSE + KEY1: go to PLAY; tempo resumes from the held value.
  - Any state + KEY3: go to STOP; step=0; tempo=0.
  - STOP or PAUSE + KEY2: step advances by 1 with wrap; tempo unchanged; no `step_tick` pulse.
  - PLAY + KEY2: ignored.
- **Tempo counter.** Counts only in PLAY, from 0 to TICKS_PER_STEP-1. On the terminal count: tempo goes to 0, step advances, and `step_tick`=1 for that one cycle.
- **Step wrap.** Step SEQ_LEN-1 advances to 0. Step never reaches or exceeds SEQ_LEN. Counter widths are `$clog2(TICKS_PER_STEP)`, `$clog2(DB_TICKS+1)` and 5 bits for step.
- **ROM path.** `rom_addr` follows step and `bank_sync` with no register stage. `freq_num` is captured from `rom_data` unconditionally every cycle, so the ROM is refetched on any step or bank change. Consumers qualify `freq_num` with `note_on`.
- **Reset values.** state=STOP, step=0, tempo=0, debounce counters=0, `deb`=1, `seq_num`=0, `rom_addr`=0, `freq_num`=0, `note_on`=0, `step_tick`=0.
- **Reset mid-operation.** `KEY0` low clears everything immediately, without waiting for a clock edge. Operation restarts in STOP.

## Timing
- **Key press latency.** Raw key held low, first sampled at edge E: the action takes effect at edge E+DB_TICKS+1.
- **Bounce rejection.** A low pulse sampled on fewer than DB_TICKS+... consecutive synced edges, i.e. shorter than DB_TICKS synced cycles, produces no event.
- **PLAY entry.** From the edge entering PLAY, the first `step_tick` occurs TICKS_PER_STEP edges later. Ticks then repeat every TICKS_PER_STEP cycles while in PLAY.
- **Step-to-frequency latency.** Step changes at edge N → `rom_addr` is valid after edge N → the ROM drives data after edge N+1 → `freq_num` is updated after edge N+2.
- **Bank latency.** A `bank` change reaches `rom_addr` 2 edges later and `freq_num` 4 edges later.
- **Output qualification.** `note_on` and `state` change on the same edge as the FSM transition. `step_tick` is registered and aligned with the step update.

## Test plan
Parameters for all scenarios: TICKS_PER_STEP=4, DB_TICKS=3, SEQ_LEN=5, and a bench ROM returning `rom_data = rom_addr + 10` one cycle after the address.

1. **Reset.** Drive KEY0=0 mid-cycle with the block in PLAY at step 3 → all outputs go to their reset values immediately, with state=0 and seq_num=0.
2. **Play and wrap.** Press KEY1 with a clean hold of 10 cycles → PLAY at edge E+4. `step_tick` every 4 cycles; seq_num runs 1, 2, 3, 4, 0. `freq_num` equals 10 + `rom_addr` two edges after each step change.
3. **Bounce rejection.** KEY2 low for 2 cycles, high for 1, low for 2, then high, in STOP → seq_num stays 0. A subsequent clean 6-cycle press → seq_num=1.
4. **Pause and resume.** In PLAY, press KEY1 when tempo=2 → PAUSE and `note_on`=0. Wait 20 cycles → no `step_tick`. Press KEY1 again → the next `step_tick` comes 2 cycles after re-entering PLAY.
5. **Priority.** KEY1, KEY2 and KEY3 pressed simultaneously while in PLAY at step 3 → STOP, seq_num=0, tempo=0, no `step_tick`.
6. **Bank switch.** With seq_num=2, change `bank` from 0 to 2 → `rom_addr` goes from 2 to 66 after 2 edges, and `freq_num` goes from 12 to 76 after 4 edges.
